// File: rtl/data_mem_lsu.sv
// MEM-stage load/store unit: validates one RV32I load/store per handshake, drives the
// byte-enable word memory for a single ACCESS cycle and returns a registered response.
module data_mem_lsu #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [2:0]            i_req_funct3,
  input  logic [31:0]           i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_fault,
  output logic                  o_mem_enable,
  output logic                  o_mem_write_enable,
  output logic [3:0]            o_mem_byte_enable,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_accept;
  logic                    w_fault;
  logic                    r_write;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_fault;

  // Misalignment, out-of-range address or an encoding that has no RV32I meaning.
  function automatic logic f_fault(input logic write, input logic [2:0] funct3,
                                   input logic [31:0] addr);
    logic bad_f3;
    logic misal;
    logic range;
    range = |addr[31:ADDR_WIDTH];
    if (write) begin
      bad_f3 = (funct3 > 3'd2);
    end else begin
      bad_f3 = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
    end
    case (funct3[1:0])
      2'b01:   misal = addr[0];
      2'b10:   misal = |addr[1:0];
      default: misal = 1'b0;
    endcase
    return bad_f3 | misal | range;
  endfunction

  function automatic logic [3:0] f_store_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the narrow datum across every lane so the byte enables pick the right copy.
  function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] f_load_data(input logic [2:0] funct3, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = rdata[{lane[1], 4'b0000} +: 16];
    case (funct3)
      3'd0:    return {{24{byte_v[7]}}, byte_v};
      3'd4:    return {24'h000000, byte_v};
      3'd1:    return {{16{half_v[15]}}, half_v};
      3'd5:    return {16'h0000, half_v};
      default: return rdata;
    endcase
  endfunction

  assign w_fault      = f_fault(i_req_write, i_req_funct3, i_req_addr);
  assign o_req_ready  = (r_state == ST_IDLE) && !reset;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;

  // Next-state and acceptance decode.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_accept     = 1'b1;
          w_state_next = w_fault ? ST_RESP : ST_ACCESS;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_next = ST_RESP;
      ST_RESP:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Memory port: live only in ACCESS, and reset kills a pending store on the spot.
  always_comb begin
    o_mem_enable       = 1'b0;
    o_mem_write_enable = 1'b0;
    o_mem_byte_enable  = 4'h0;
    o_mem_address      = {ADDR_WIDTH{1'b0}};
    o_mem_write_data   = {DATA_WIDTH{1'b0}};
    if ((r_state == ST_ACCESS) && !reset) begin
      o_mem_enable       = 1'b1;
      o_mem_write_enable = r_write;
      o_mem_address      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
      if (r_write) begin
        o_mem_byte_enable = f_store_be(r_funct3[1:0], r_addr[1:0]);
        o_mem_write_data  = f_store_data(r_funct3[1:0], r_wdata);
      end else begin
        o_mem_byte_enable = 4'hF;
        o_mem_write_data  = {DATA_WIDTH{1'b0}};
      end
    end else begin
      o_mem_enable = 1'b0;
    end
  end

  // State, latched request and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= {ADDR_WIDTH{1'b0}};
      r_wdata      <= {DATA_WIDTH{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_rdata <= {DATA_WIDTH{1'b0}};
      r_resp_fault <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= (w_state_next == ST_RESP);
      if (w_accept) begin
        r_write      <= i_req_write;
        r_funct3     <= i_req_funct3;
        r_addr       <= i_req_addr[ADDR_WIDTH-1:0];
        r_wdata      <= i_req_wdata;
        r_resp_fault <= w_fault;
        r_resp_rdata <= {DATA_WIDTH{1'b0}};
      end else if (r_state == ST_ACCESS) begin
        r_resp_fault <= 1'b0;
        r_resp_rdata <= r_write ? {DATA_WIDTH{1'b0}}
                                : f_load_data(r_funct3, r_addr[1:0], i_mem_read_data);
      end else if (r_state == ST_RESP) begin
        r_resp_fault <= 1'b0;
        r_resp_rdata <= {DATA_WIDTH{1'b0}};
      end else begin
        r_resp_fault <= r_resp_fault;
        r_resp_rdata <= r_resp_rdata;
      end
    end
  end

endmodule
